// File: rtl/pay_arbiter_pkg.sv
// Shared definitions for the kiosk payment controller: FSM encodings and
// account-related constants.
package pay_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Balance loaded into every valid account at reset.
  localparam int INIT_BAL_DEF = 100;

  // Account id 0 is reserved and never holds money.
  localparam int ID_RESERVED = 0;

endpackage

// File: rtl/pay_arbiter_rr_arbiter.sv
// Round-robin request picker: grants the first set request bit found when
// scanning upward from ptr, wrapping at N_REQ. Purely combinational.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx
);

  logic [PW-1:0] pos;
  logic          found;

  // Scan from ptr with wrap; N_REQ is a power of two so PW-bit addition wraps naturally.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = ptr + PW'(i);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/pay_arbiter.sv
// Transaction controller for the shared user-account datapath. Arbitrates
// kiosk purchases round-robin, owns the per-user balance file, checks and
// deducts, and accepts admin top-ups while idle.
//
// state | meaning
// IDLE  | accept a top-up (priority) or grant one kiosk request
// CHECK | compare balance against price, register ok/change
// RESP  | present response, commit deduction, advance RR pointer
module pay_arbiter
  import pay_arbiter_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int ID_W     = 3,
  parameter  int AMT_W    = 16,
  parameter  int INIT_BAL = INIT_BAL_DEF,
  localparam int PW       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*ID_W-1:0]  req_id,
  input  logic [N_REQ*AMT_W-1:0] req_price,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [PW-1:0]          rsp_port,
  output logic                   rsp_ok,
  output logic [AMT_W-1:0]       rsp_change,
  input  logic                   topup_valid,
  input  logic [ID_W-1:0]        topup_id,
  input  logic [AMT_W-1:0]       topup_amt,
  output logic                   topup_ready,
  output logic                   busy
);

  localparam int N_ACC = 1 << ID_W;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic             accept;
  logic             topup_fire;

  logic [PW-1:0]    g_q;
  logic [ID_W-1:0]  id_q;
  logic [AMT_W-1:0] price_q;

  logic [AMT_W-1:0] bal [N_ACC];
  logic [AMT_W-1:0] bal_cur;
  logic [AMT_W:0]   topup_sum;
  logic [AMT_W-1:0] topup_sat;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; top-ups win over kiosk requests in IDLE.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    topup_ready = 1'b0;
    accept      = 1'b0;
    topup_fire  = 1'b0;
    rsp_valid   = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (topup_valid) begin
          topup_ready = 1'b1;
          topup_fire  = 1'b1;
        end else if (|req_valid) begin
          req_ready = grant;
          accept    = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the granted kiosk's request; inputs are only looked at in the accept cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      id_q    <= '0;
      price_q <= '0;
    end else if (accept) begin
      g_q     <= grant_idx;
      id_q    <= req_id[grant_idx*ID_W +: ID_W];
      price_q <= req_price[grant_idx*AMT_W +: AMT_W];
    end
  end

  assign bal_cur = bal[id_q];

  // Response registers are loaded in CHECK so they hold between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_port   <= '0;
      rsp_ok     <= 1'b0;
      rsp_change <= '0;
    end else if (state == ST_CHECK) begin
      rsp_port <= g_q;
      if (id_q == ID_W'(ID_RESERVED)) begin
        rsp_ok     <= 1'b0;
        rsp_change <= '0;
      end else if (bal_cur >= price_q) begin
        rsp_ok     <= 1'b1;
        rsp_change <= bal_cur - price_q;
      end else begin
        rsp_ok     <= 1'b0;
        rsp_change <= bal_cur;
      end
    end
  end

  // Round-robin pointer moves past the kiosk just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr <= '0;
    else if (state == ST_RESP)  ptr <= g_q + PW'(1);
  end

  assign topup_sum = {1'b0, bal[topup_id]} + {1'b0, topup_amt};
  assign topup_sat = topup_sum[AMT_W] ? {AMT_W{1'b1}} : topup_sum[AMT_W-1:0];

  // Balance file. Top-ups only happen in IDLE and deductions only in RESP, so
  // the two write sources never collide. The reserved slot is kept at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ACC; i++)
        bal[i] <= (i == ID_RESERVED) ? '0 : AMT_W'(INIT_BAL);
    end else if (topup_fire) begin
      if (topup_id != ID_W'(ID_RESERVED)) bal[topup_id] <= topup_sat;
    end else if (state == ST_RESP && rsp_ok) begin
      bal[id_q] <= rsp_change;
    end
  end

endmodule

// File: tb/tb_pay_arbiter.sv
// Directed bench for pay_arbiter with a response scoreboard.
module tb_pay_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 3;
  localparam int AMT_W = 16;
  localparam int PW    = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*ID_W-1:0]  req_id;
  logic [N_REQ*AMT_W-1:0] req_price;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic [PW-1:0]          rsp_port;
  logic                   rsp_ok;
  logic [AMT_W-1:0]       rsp_change;
  logic                   topup_valid;
  logic [ID_W-1:0]        topup_id;
  logic [AMT_W-1:0]       topup_amt;
  logic                   topup_ready;
  logic                   busy;

  pay_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .AMT_W(AMT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_price   (req_price),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_port    (rsp_port),
    .rsp_ok      (rsp_ok),
    .rsp_change  (rsp_change),
    .topup_valid (topup_valid),
    .topup_id    (topup_id),
    .topup_amt   (topup_amt),
    .topup_ready (topup_ready),
    .busy        (busy)
  );

  typedef struct {
    int port;
    int ok;
    int change;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response strobe must match the oldest expectation, two cycles after accept.
  always @(negedge clk) begin
    if (rsp_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp port=%0d ok=%0d change=%0d", rsp_port, rsp_ok, rsp_change);
      end else begin
        e = q.pop_front();
        if (int'(rsp_port) != e.port || int'(rsp_ok) != e.ok || int'(rsp_change) != e.change) begin
          fails++;
          $display("FAIL rsp got port=%0d ok=%0d change=%0d want port=%0d ok=%0d change=%0d",
                   rsp_port, rsp_ok, rsp_change, e.port, e.ok, e.change);
        end
        tests++;
        if (cyc != e.cyc + 2) begin
          fails++;
          $display("FAIL rsp_latency got %0d want %0d", cyc - e.cyc, 2);
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Wait (bounded) for an acceptance with inputs as currently driven; check
  // the grant vector and queue the expected response.
  task automatic wait_grant(input logic [3:0] exp_rdy, input int port, input int ok,
                            input int change, input string nm);
    int n = 0;
    bit got = 0;
    while (!got) begin
      #1;
      if (req_ready != 0) got = 1;
      else if (n >= 20) break;
      else begin
        n++;
        @(negedge clk);
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s grant_timeout got=0 want=%0d", nm, exp_rdy);
    end else begin
      if (req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL %s req_ready got=%b want=%b", nm, req_ready, exp_rdy);
      end
      q.push_back('{port, ok, change, cyc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int id, input int price);
    req_id[k*ID_W +: ID_W]     = ID_W'(id);
    req_price[k*AMT_W +: AMT_W] = AMT_W'(price);
    req_valid[k]               = 1'b1;
  endtask

  task automatic issue(input int k, input int id, input int price, input int ok,
                       input int change, input string nm);
    logic [3:0] oh;
    oh = 4'(1) << k;
    set_req(k, id, price);
    wait_grant(oh, k, ok, change, nm);
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  int exp_bal [8] = '{0, 70, 0, 100, 99, 70, 80, 100};

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_id      = '0;
    req_price   = '0;
    topup_valid = 1'b0;
    topup_id    = '0;
    topup_amt   = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",   int'(req_ready), 0);
    check("rst_rsp_valid",   int'(rsp_valid), 0);
    check("rst_rsp_change",  int'(rsp_change), 0);
    check("rst_rsp_ok_port", int'({rsp_ok, rsp_port}), 0);
    check("rst_topup_ready", int'(topup_ready), 0);
    check("rst_busy",        int'(busy), 0);
    rst_n = 1'b1;

    // Basic purchases and an insufficient balance.
    issue(0, 1, 15, 1, 85, "k0_id1_p15");
    issue(0, 1, 15, 1, 70, "k0_id1_p15_again");
    issue(1, 2, 200, 0, 100, "k1_id2_p200");
    issue(1, 2, 100, 1, 0, "k1_id2_p100");
    issue(3, 4, 0, 1, 100, "k3_id4_p0");

    // Held requests on kiosks 0 and 2 alternate; kiosk 3 joins after a grant to 2.
    set_req(0, 5, 10);
    set_req(2, 6, 10);
    wait_grant(4'b0001, 0, 1, 90, "rr_g0_a");
    wait_grant(4'b0100, 2, 1, 90, "rr_g2_a");
    wait_grant(4'b0001, 0, 1, 80, "rr_g0_b");
    wait_grant(4'b0100, 2, 1, 80, "rr_g2_b");
    set_req(3, 4, 1);
    wait_grant(4'b1000, 3, 1, 99, "rr_g3");
    req_valid[3] = 1'b0;
    wait_grant(4'b0001, 0, 1, 70, "rr_g0_c");
    req_valid = '0;

    // Reserved id is rejected and touches no account.
    issue(0, 0, 5, 0, 0, "id0_p5");
    for (int i = 1; i < 8; i++) issue(i % 4, i, 0, 1, exp_bal[i], "bal_readback");

    // Saturating top-up.
    wait_idle();
    topup_valid = 1'b1;
    topup_id    = 3'd7;
    topup_amt   = 16'd65500;
    #1;
    check("topup_ready_idle", int'(topup_ready), 1);
    @(posedge clk);
    #1;
    topup_valid = 1'b0;
    issue(3, 7, 0, 1, 65535, "id7_saturated");

    // Top-up beats a pending request; the request goes next cycle and sees the credit.
    wait_idle();
    topup_valid = 1'b1;
    topup_id    = 3'd1;
    topup_amt   = 16'd5;
    set_req(1, 1, 10);
    #1;
    check("prio_topup_ready", int'(topup_ready), 1);
    check("prio_req_held",    int'(req_ready), 0);
    @(posedge clk);
    #1;
    topup_valid = 1'b0;
    @(negedge clk);
    #1;
    check("prio_req_next", int'(req_ready), 4'b0010);
    if (req_ready == 4'b0010) q.push_back('{1, 1, 65, cyc});
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;

    // Top-up waits while the FSM is busy.
    topup_valid = 1'b1;
    topup_id    = 3'd2;
    topup_amt   = 16'd1;
    @(negedge clk);
    #1;
    check("topup_wait_check", int'(topup_ready), 0);
    @(negedge clk);
    #1;
    check("topup_wait_resp", int'(topup_ready), 0);
    @(negedge clk);
    #1;
    check("topup_taken_idle", int'(topup_ready), 1);
    @(posedge clk);
    #1;
    topup_valid = 1'b0;
    issue(2, 2, 0, 1, 1, "id2_after_topup");

    // Reset in CHECK abandons the transaction.
    wait_idle();
    set_req(2, 3, 30);
    #1;
    check("rst_mid_accept", int'(req_ready), 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_rsp", int'(rsp_valid), 0);
    end
    rst_n = 1'b1;
    issue(2, 3, 0, 1, 100, "id3_after_rst");

    begin
      int n = 0;
      while (q.size() != 0 && n < 20) begin
        n++;
        @(negedge clk);
      end
    end
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
